// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encodings, the default watchdog limit and the port-eligibility rule.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_WAIT = 2'd1,
    INST_WAIT = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  // A port that has just completed must not be re-issued in its valid cycle.
  function automatic logic port_eligible(input logic ce, input logic valid);
    return ce & ~valid;
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Access watchdog: clear/enable counter that flags expiry after TIMEOUT-1
// counted cycles and saturates instead of wrapping.
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count_r;

  // Wait-cycle counter; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en && (count_r != MAX)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one
// variable-latency memory; data wins over fetch, watchdog aborts hung accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_ce_i,
  input  logic [AW-1:0] inst_addr_i,
  output logic [DW-1:0] inst_o,
  output logic          inst_valid_o,
  input  logic          data_ce_i,
  input  logic          data_we_i,
  input  logic [AW-1:0] data_addr_i,
  input  logic [DW-1:0] data_wdata_i,
  output logic [DW-1:0] data_o,
  output logic          data_valid_o,
  output logic          stall_req_if_o,
  output logic          stall_req_mem_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          bus_err_o
);

  arb_state_e state_r;
  logic       wait_s;
  logic       wd_clr_s;
  logic       wd_expired_s;
  logic       data_elig_s;
  logic       inst_elig_s;

  assign wait_s      = (state_r != IDLE);
  assign wd_clr_s    = ~wait_s | mem_ack_i | wd_expired_s;
  assign data_elig_s = port_eligible(data_ce_i, data_valid_o);
  assign inst_elig_s = port_eligible(inst_ce_i, inst_valid_o);

  assign stall_req_if_o  = inst_ce_i & ~inst_valid_o;
  assign stall_req_mem_o = data_ce_i & ~data_valid_o;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wait_s),
    .expired (wd_expired_s)
  );

  // Arbitration FSM with registered memory-side and port-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= {AW{1'b0}};
      mem_wdata_o  <= {DW{1'b0}};
      inst_o       <= {DW{1'b0}};
      inst_valid_o <= 1'b0;
      data_o       <= {DW{1'b0}};
      data_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      data_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (data_elig_s) begin
            state_r     <= DATA_WAIT;
            mem_req_o   <= 1'b1;
            mem_we_o    <= data_we_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
          end else if (inst_elig_s) begin
            state_r    <= INST_WAIT;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= inst_addr_i;
          end else begin
            state_r   <= IDLE;
            mem_req_o <= 1'b0;
          end
        end
        DATA_WAIT: begin
          // An ack in the expiry cycle still completes the access normally.
          if (mem_ack_i) begin
            state_r      <= IDLE;
            mem_req_o    <= 1'b0;
            data_o       <= mem_we_o ? {DW{1'b0}} : mem_rdata_i;
            data_valid_o <= 1'b1;
          end else if (wd_expired_s) begin
            state_r      <= IDLE;
            mem_req_o    <= 1'b0;
            data_o       <= {DW{1'b0}};
            data_valid_o <= 1'b1;
            bus_err_o    <= 1'b1;
          end else begin
            state_r <= DATA_WAIT;
          end
        end
        INST_WAIT: begin
          if (mem_ack_i) begin
            state_r      <= IDLE;
            mem_req_o    <= 1'b0;
            inst_o       <= mem_rdata_i;
            inst_valid_o <= 1'b1;
          end else if (wd_expired_s) begin
            state_r      <= IDLE;
            mem_req_o    <= 1'b0;
            inst_o       <= {DW{1'b0}};
            inst_valid_o <= 1'b1;
            bus_err_o    <= 1'b1;
          end else begin
            state_r <= INST_WAIT;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        stall_req_if_o;
  logic        stall_req_mem_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        mem_ack_i = 1'b0;
  logic        bus_err_o;

  int n_chk  = 0;
  int n_pass = 0;

  // memory environment
  int          lat_q[$];
  acc_t        acc_log[$];
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  bit          spur_ack = 1'b0;
  bit          in_acc   = 1'b0;
  int          cyc      = 0;
  int          cur_lat  = 0;

  mem_arbiter #(.TIMEOUT(TO), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_o(data_o), .data_valid_o(data_valid_o),
    .stall_req_if_o(stall_req_if_o), .stall_req_mem_o(stall_req_mem_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // Memory responder: ack after the configured number of extra request cycles.
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        cyc = 0;
        if (lat_q.size() > 0) cur_lat = lat_q.pop_front();
        else cur_lat = 0;
        acc_log.push_back({mem_we_o, mem_addr_o, mem_wdata_o});
      end else begin
        cyc++;
      end
      if (cyc == cur_lat) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) begin
          mem_img[mem_addr_o] = mem_wdata_o;
          mem_rdata_i = $urandom;
        end else if (mem_img.exists(mem_addr_o)) begin
          mem_rdata_i = mem_img[mem_addr_o];
        end else begin
          mem_rdata_i = dflt(mem_addr_o);
        end
      end else begin
        mem_ack_i = 1'b0;
        mem_rdata_i = $urandom;
      end
    end else begin
      in_acc = 1'b0;
      mem_ack_i = spur_ack;
      mem_rdata_i = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_ce_i = 1'b1; inst_addr_i = 32'h4;
    data_ce_i = 1'b0; data_we_i = 1'b0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    tick(); tick();
    n_chk++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, inst_o, data_o, inst_valid_o, data_valid_o, bus_err_o} !== '0)
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h inst=%h data=%h iv=%b dv=%b err=%b, required all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, inst_o, data_o, inst_valid_o, data_valid_o, bus_err_o);
    else n_pass++;
    n_chk++;
    if ({stall_req_if_o, stall_req_mem_o} !== 2'b10)
      $display("FAIL reset_stalls: got %b required 10", {stall_req_if_o, stall_req_mem_o});
    else n_pass++;
    rst = 1'b0; inst_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int req_n, val_n, val_step, stall_bad;
    logic [31:0] got;
    acc_t e;
    req_n = 0; val_n = 0; val_step = -1; stall_bad = 0; got = 32'h0;
    mem_img[32'h4] = 32'h0010_0093;
    lat_q.push_back(2);
    acc_log.delete();
    inst_addr_i = 32'h4; inst_ce_i = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      tick();
      if (mem_req_o) req_n++;
      if (inst_valid_o) begin
        val_n++;
        if (val_step < 0) begin val_step = s; got = inst_o; end
        if (stall_req_if_o !== 1'b0) stall_bad++;
        inst_ce_i = 1'b0;
      end else if (inst_ce_i && stall_req_if_o !== 1'b1) begin
        stall_bad++;
      end
    end
    n_chk++; if (req_n != 3) $display("FAIL fetch_req_cycles: got %0d required 3", req_n); else n_pass++;
    n_chk++; if (val_n != 1) $display("FAIL fetch_valid_pulses: got %0d required 1", val_n); else n_pass++;
    n_chk++; if (val_step != 4) $display("FAIL fetch_latency: got %0d required 4", val_step); else n_pass++;
    n_chk++; if (got !== 32'h0010_0093) $display("FAIL fetch_data: got %h required 00100093", got); else n_pass++;
    n_chk++; if (stall_bad != 0) $display("FAIL fetch_stall: %0d bad cycles, required 0", stall_bad); else n_pass++;
    e = '0;
    if (acc_log.size() > 0) e = acc_log[0];
    n_chk++;
    if (acc_log.size() != 1 || e.we !== 1'b0 || e.addr !== 32'h4)
      $display("FAIL fetch_bus: n=%0d we=%b addr=%h, required n=1 we=0 addr=00000004", acc_log.size(), e.we, e.addr);
    else n_pass++;
  endtask

  task automatic test_priority();
    int dstep, istep, nstart;
    int starts[2];
    logic prev_req;
    logic [31:0] dgot, igot;
    acc_t e0, e1;
    dstep = -1; istep = -1; nstart = 0; starts[0] = -1; starts[1] = -1; prev_req = 1'b0;
    dgot = 32'h0; igot = 32'h0;
    mem_img[32'h100] = 32'hCAFE_0100;
    mem_img[32'h40]  = 32'h1357_9BDF;
    lat_q.push_back(1); lat_q.push_back(1);
    acc_log.delete();
    inst_addr_i = 32'h40; inst_ce_i = 1'b1;
    data_addr_i = 32'h100; data_we_i = 1'b0; data_ce_i = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      tick();
      if (mem_req_o && !prev_req && nstart < 2) begin starts[nstart] = s; nstart++; end
      prev_req = mem_req_o;
      if (data_valid_o) begin dstep = s; dgot = data_o; data_ce_i = 1'b0; end
      if (inst_valid_o) begin istep = s; igot = inst_o; inst_ce_i = 1'b0; end
    end
    e0 = '0; e1 = '0;
    if (acc_log.size() > 1) begin e0 = acc_log[0]; e1 = acc_log[1]; end
    n_chk++;
    if (e0.addr !== 32'h100 || e0.we !== 1'b0 || e1.addr !== 32'h40)
      $display("FAIL prio_order: first=%h/we%b second=%h, required 00000100/we0 then 00000040", e0.addr, e0.we, e1.addr);
    else n_pass++;
    n_chk++; if (dstep != 3 || dgot !== 32'hCAFE_0100) $display("FAIL prio_load: step %0d data %h, required 3 cafe0100", dstep, dgot); else n_pass++;
    n_chk++; if (starts[1] != 4) $display("FAIL prio_fetch_issue: started %0d, required 4", starts[1]); else n_pass++;
    n_chk++; if (istep != 6 || igot !== 32'h1357_9BDF) $display("FAIL prio_fetch: step %0d data %h, required 6 13579bdf", istep, igot); else n_pass++;
  endtask

  task automatic test_store();
    int reqn, vn, vstep;
    logic we_seen;
    logic [31:0] wd_seen, dgot;
    reqn = 0; vn = 0; vstep = -1; we_seen = 1'b0; wd_seen = 32'h0; dgot = 32'hFFFF_FFFF;
    lat_q.push_back(0);
    acc_log.delete();
    data_we_i = 1'b1; data_addr_i = 32'h200; data_wdata_i = 32'hDEAD_BEEF; data_ce_i = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      tick();
      // requester keeps ce up through the valid cycle to probe re-issue blocking
      if (vstep > 0 && s == vstep + 1) data_ce_i = 1'b0;
      if (mem_req_o) begin reqn++; we_seen = mem_we_o; wd_seen = mem_wdata_o; end
      if (data_valid_o) begin vn++; vstep = s; dgot = data_o; end
    end
    data_we_i = 1'b0;
    n_chk++; if (reqn != 1) $display("FAIL store_req_cycles: got %0d required 1", reqn); else n_pass++;
    n_chk++;
    if (we_seen !== 1'b1 || wd_seen !== 32'hDEAD_BEEF)
      $display("FAIL store_bus: we=%b wdata=%h, required 1 deadbeef", we_seen, wd_seen);
    else n_pass++;
    n_chk++; if (vn != 1 || vstep != 2) $display("FAIL store_valid: %0d pulses at %0d, required 1 at 2", vn, vstep); else n_pass++;
    n_chk++; if (dgot !== 32'h0) $display("FAIL store_data_o: got %h required 0", dgot); else n_pass++;
    n_chk++; if (acc_log.size() != 1) $display("FAIL store_no_dup: %0d accesses, required 1", acc_log.size()); else n_pass++;
  endtask

  task automatic test_timeout();
    int reqn, en, vn, vstep, bad, dvn;
    logic [31:0] got;
    reqn = 0; en = 0; vn = 0; vstep = -1; bad = 0; dvn = 0; got = 32'hFFFF_FFFF;
    lat_q.push_back(100);
    inst_addr_i = 32'h80; inst_ce_i = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      tick();
      if (mem_req_o) reqn++;
      if (data_valid_o) dvn++;
      if (bus_err_o) begin en++; if (!inst_valid_o) bad++; end
      if (inst_valid_o) begin vn++; vstep = s; got = inst_o; inst_ce_i = 1'b0; end
    end
    n_chk++; if (reqn != TO) $display("FAIL timeout_req_cycles: got %0d required %0d", reqn, TO); else n_pass++;
    n_chk++; if (en != 1 || bad != 0) $display("FAIL timeout_bus_err: %0d pulses, %0d unpaired, required 1 and 0", en, bad); else n_pass++;
    n_chk++; if (vn != 1 || vstep != TO + 1) $display("FAIL timeout_valid: %0d pulses at %0d, required 1 at %0d", vn, vstep, TO + 1); else n_pass++;
    n_chk++; if (got !== 32'h0 || dvn != 0) $display("FAIL timeout_data: inst=%h dvalids=%0d, required 0 and 0", got, dvn); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad, vstep;
    logic [31:0] dgot;
    bad = 0; vstep = -1; dgot = 32'h0;
    lat_q.push_back(100); lat_q.push_back(1);
    mem_img[32'h300] = 32'h0BAD_F00D;
    data_we_i = 1'b0; data_addr_i = 32'h300; data_ce_i = 1'b1;
    tick();
    tick();
    n_chk++; if (mem_req_o !== 1'b1) $display("FAIL rstmid_pending: req=%b required 1", mem_req_o); else n_pass++;
    rst = 1'b1;
    tick();
    if (data_valid_o || bus_err_o) bad++;
    n_chk++; if (mem_req_o !== 1'b0) $display("FAIL rstmid_drop: req=%b required 0", mem_req_o); else n_pass++;
    rst = 1'b0;
    tick();
    if (data_valid_o || bus_err_o) bad++;
    n_chk++; if (mem_req_o !== 1'b1) $display("FAIL rstmid_reissue: req=%b required 1", mem_req_o); else n_pass++;
    for (int s = 5; s <= 12; s++) begin
      tick();
      if (bus_err_o) bad++;
      if (data_valid_o) begin
        if (vstep > 0) bad++;
        vstep = s; dgot = data_o; data_ce_i = 1'b0;
      end
    end
    n_chk++; if (bad != 0) $display("FAIL rstmid_spurious: %0d unexpected pulses, required 0", bad); else n_pass++;
    n_chk++; if (vstep != 6 || dgot !== 32'h0BAD_F00D) $display("FAIL rstmid_load: step %0d data %h, required 6 0badf00d", vstep, dgot); else n_pass++;
  endtask

  task automatic test_spurious_ack();
    int bad;
    bad = 0;
    spur_ack = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      if (inst_valid_o || data_valid_o || bus_err_o || mem_req_o) bad++;
    end
    spur_ack = 1'b0;
    tick();
    n_chk++; if (bad != 0) $display("FAIL spurious_ack: %0d active cycles, required 0", bad); else n_pass++;
  endtask

  task automatic test_random();
    int kind, ld, li, d_k, i_k, d_step, i_step, exp_err, nerr;
    int dstep, istep, dcnt, icnt, stall_bad;
    bit do_d, do_i, d_ok, i_ok;
    logic we;
    logic [31:0] da, ia, wd, d_exp, i_exp, dgot, igot;
    acc_t e0, e1, exp0, exp1;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      do_d = (kind != 2);
      do_i = (kind >= 2);
      we = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      da = 32'h2000 + ($urandom_range(0, 7) << 2);
      ia = 32'h1000 + ($urandom_range(0, 63) << 2);
      wd = $urandom;
      ld = $urandom_range(0, 9);
      li = $urandom_range(0, 9);
      // transaction-level expectations
      d_ok = (ld < TO); i_ok = (li < TO);
      d_k = d_ok ? ld + 1 : TO;
      i_k = i_ok ? li + 1 : TO;
      d_exp = (!d_ok || we) ? 32'h0 : ref_rd(da);
      if (do_d && d_ok && we) ref_mem[da] = wd;
      i_exp = i_ok ? ref_rd(ia) : 32'h0;
      d_step = d_k + 1;
      i_step = (do_d ? d_k + 1 : 0) + i_k + 1;
      exp_err = ((do_d && !d_ok) ? 1 : 0) + ((do_i && !i_ok) ? 1 : 0);
      exp0 = do_d ? {we, da, (we ? wd : 32'h0)} : {1'b0, ia, 32'h0};
      exp1 = {1'b0, ia, 32'h0};
      if (do_d) lat_q.push_back(ld);
      if (do_i) lat_q.push_back(li);
      acc_log.delete();
      dstep = -1; istep = -1; dcnt = 0; icnt = 0; nerr = 0; stall_bad = 0;
      dgot = 32'h0; igot = 32'h0;
      data_we_i = we; data_addr_i = da; data_wdata_i = wd; data_ce_i = do_d;
      inst_addr_i = ia; inst_ce_i = do_i;
      for (int s = 1; s <= 22; s++) begin
        tick();
        if (stall_req_if_o !== (inst_ce_i & ~inst_valid_o)) stall_bad++;
        if (stall_req_mem_o !== (data_ce_i & ~data_valid_o)) stall_bad++;
        if (bus_err_o) nerr++;
        if (data_valid_o) begin dcnt++; dstep = s; dgot = data_o; data_ce_i = 1'b0; end
        if (inst_valid_o) begin icnt++; istep = s; igot = inst_o; inst_ce_i = 1'b0; end
      end
      e0 = '0; e1 = '0;
      if (acc_log.size() > 0) e0 = acc_log[0];
      if (acc_log.size() > 1) e1 = acc_log[1];
      if (!(do_d && we)) e0.wdata = 32'h0;
      e1.wdata = 32'h0;
      if (do_d) begin
        n_chk++;
        if (dcnt != 1 || dstep != d_step || dgot !== d_exp)
          $display("FAIL rnd%0d_data: %0d pulses step %0d data %h, required 1 step %0d data %h", t, dcnt, dstep, dgot, d_step, d_exp);
        else n_pass++;
      end
      if (do_i) begin
        n_chk++;
        if (icnt != 1 || istep != i_step || igot !== i_exp)
          $display("FAIL rnd%0d_inst: %0d pulses step %0d data %h, required 1 step %0d data %h", t, icnt, istep, igot, i_step, i_exp);
        else n_pass++;
      end
      n_chk++;
      if (nerr != exp_err) $display("FAIL rnd%0d_bus_err: got %0d required %0d", t, nerr, exp_err);
      else n_pass++;
      n_chk++;
      if (acc_log.size() != (do_d + do_i) || e0 !== exp0 || (do_d && do_i && e1 !== exp1))
        $display("FAIL rnd%0d_bus: n=%0d first=%h second=%h, required n=%0d first=%h second=%h",
                 t, acc_log.size(), e0, e1, do_d + do_i, exp0, exp1);
      else n_pass++;
      n_chk++;
      if (stall_bad != 0) $display("FAIL rnd%0d_stall: %0d bad cycles, required 0", t, stall_bad);
      else n_pass++;
      for (int g = 0; g < $urandom_range(0, 2); g++) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget, required completion");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_timeout();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
